// File: rtl/cmd_rx_parser.sv
// Host packet parser: UART RX bytes -> single-cycle CSR write/read strobes; read data returned as 4 TX bytes.
// Optional CRC-8 trailer (poly 0x07) is compiled in when the macro CMD_RX_CRC_EN is defined.
module cmd_rx_parser #(
  parameter logic [31:0] TIMEOUT_CYC = 32'd100000,
  parameter int unsigned ADDR_W      = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  input  logic              crc_en,
  output logic              csr_wen,
  output logic              csr_ren,
  output logic [ADDR_W-1:0] csr_addr,
  output logic [31:0]       csr_wdata,
  input  logic [31:0]       csr_rdata,
  output logic              tx_valid,
  output logic [7:0]        tx_data,
  input  logic              tx_ready,
  output logic              rx_crc_error,
  output logic              rx_illegal_cmd,
  output logic              rx_timeout,
  output logic              busy
);

`ifdef CMD_RX_CRC_EN
  localparam logic CRC_BUILD = 1'b1;
`else
  localparam logic CRC_BUILD = 1'b0;
`endif

  localparam logic [7:0] CMD_WR = 8'h01;
  localparam logic [7:0] CMD_RD = 8'h02;

  typedef enum logic [3:0] {
    S_IDLE = 4'd0, S_ADDR = 4'd1, S_D0 = 4'd2, S_D1 = 4'd3, S_D2 = 4'd4, S_D3 = 4'd5,
    S_CRC = 4'd6, S_EXEC = 4'd7, S_RD_WAIT = 4'd8,
    S_TX0 = 4'd9, S_TX1 = 4'd10, S_TX2 = 4'd11, S_TX3 = 4'd12
  } state_e;

  state_e            state_q, state_d;
  logic [31:0]       cnt_q, cnt_d;
  logic [7:0]        crc_q, crc_d;
  logic              crc_act_q, crc_act_d;
  logic              is_rd_q, is_rd_d;
  logic [7:0]        addr_q, addr_d;
  logic [31:0]       data_q, data_d;
  logic [31:0]       cap_q, cap_d;
  logic              rx_ready_q, rx_ready_d;
  logic              csr_wen_q, csr_wen_d;
  logic              csr_ren_q, csr_ren_d;
  logic [ADDR_W-1:0] csr_addr_q, csr_addr_d;
  logic [31:0]       csr_wdata_q, csr_wdata_d;
  logic              tx_valid_q, tx_valid_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic              crc_err_q, crc_err_d;
  logic              ill_q, ill_d;
  logic              to_q, to_d;
  logic              busy_q, busy_d;
  logic              acc_s, wait_s, last_s, crc_bad_s;

  function automatic logic [7:0] crc8_upd(input logic [7:0] crc, input logic [7:0] b);
    logic [7:0] c;
    c = crc ^ b;
    for (int i = 0; i < 8; i++) begin
      if (c[7]) begin
        c = {c[6:0], 1'b0} ^ 8'h07;
      end else begin
        c = {c[6:0], 1'b0};
      end
    end
    return c;
  endfunction

  // Next-state and next-output computation for the whole parser.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    crc_d       = crc_q;
    crc_act_d   = crc_act_q;
    is_rd_d     = is_rd_q;
    addr_d      = addr_q;
    data_d      = data_q;
    cap_d       = cap_q;
    csr_addr_d  = csr_addr_q;
    csr_wdata_d = csr_wdata_q;
    tx_valid_d  = tx_valid_q;
    tx_data_d   = tx_data_q;
    csr_wen_d   = 1'b0;
    csr_ren_d   = 1'b0;
    crc_err_d   = 1'b0;
    ill_d       = 1'b0;
    to_d        = 1'b0;
    wait_s      = 1'b0;
    last_s      = 1'b0;
    crc_bad_s   = 1'b0;
    acc_s       = rx_valid & rx_ready_q;

    case (state_q)
      S_IDLE: begin
        if (acc_s && ((rx_data == CMD_WR) || (rx_data == CMD_RD))) begin
          state_d   = S_ADDR;
          is_rd_d   = (rx_data == CMD_RD);
          crc_act_d = CRC_BUILD & crc_en;
          crc_d     = crc8_upd(8'h00, rx_data);
        end else if (acc_s) begin
          ill_d = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ADDR: begin
        wait_s = 1'b1;
        if (acc_s) begin
          addr_d = rx_data;
          crc_d  = crc8_upd(crc_q, rx_data);
          if (!is_rd_q) begin
            state_d = S_D0;
          end else if (crc_act_q) begin
            state_d = S_CRC;
          end else begin
            last_s = 1'b1;
          end
        end else begin
          state_d = S_ADDR;
        end
      end
      S_D0, S_D1, S_D2, S_D3: begin
        wait_s = 1'b1;
        if (acc_s) begin
          data_d = {rx_data, data_q[31:8]};
          crc_d  = crc8_upd(crc_q, rx_data);
          if (state_q != S_D3) begin
            state_d = state_e'(state_q + 4'd1);
          end else if (crc_act_q) begin
            state_d = S_CRC;
          end else begin
            last_s = 1'b1;
          end
        end else begin
          state_d = state_q;
        end
      end
      S_CRC: begin
        wait_s = 1'b1;
        if (acc_s) begin
          crc_bad_s = (rx_data != crc_q);
          last_s    = 1'b1;
        end else begin
          state_d = S_CRC;
        end
      end
      S_EXEC: begin
        state_d = csr_ren_q ? S_RD_WAIT : S_IDLE;
      end
      S_RD_WAIT: begin
        cap_d      = csr_rdata;
        tx_data_d  = csr_rdata[7:0];
        tx_valid_d = 1'b1;
        state_d    = S_TX0;
      end
      S_TX0: begin
        if (tx_ready) begin
          tx_data_d = cap_q[15:8];
          state_d   = S_TX1;
        end else begin
          state_d = S_TX0;
        end
      end
      S_TX1: begin
        if (tx_ready) begin
          tx_data_d = cap_q[23:16];
          state_d   = S_TX2;
        end else begin
          state_d = S_TX1;
        end
      end
      S_TX2: begin
        if (tx_ready) begin
          tx_data_d = cap_q[31:24];
          state_d   = S_TX3;
        end else begin
          state_d = S_TX2;
        end
      end
      S_TX3: begin
        if (tx_ready) begin
          tx_valid_d = 1'b0;
          tx_data_d  = 8'h00;
          state_d    = S_IDLE;
        end else begin
          state_d = S_TX3;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Last byte of a packet: CRC error outranks a misaligned address; only a clean packet strobes.
    if (last_s) begin
      state_d = S_EXEC;
      if (crc_bad_s) begin
        crc_err_d = 1'b1;
      end else if (addr_d[1:0] != 2'b00) begin
        ill_d = 1'b1;
      end else begin
        csr_addr_d  = ADDR_W'(addr_d);
        csr_wdata_d = is_rd_q ? csr_wdata_q : data_d;
        csr_wen_d   = ~is_rd_q;
        csr_ren_d   = is_rd_q;
      end
    end else begin
      crc_bad_s = 1'b0;
    end

    // An accepted byte in the compare cycle wins over the timeout.
    if (!wait_s) begin
      cnt_d = 32'd0;
    end else if (acc_s) begin
      cnt_d = 32'd0;
    end else if ((cnt_q + 32'd1) == TIMEOUT_CYC) begin
      cnt_d   = 32'd0;
      to_d    = 1'b1;
      state_d = S_IDLE;
    end else begin
      cnt_d = cnt_q + 32'd1;
    end

    rx_ready_d = state_d inside {S_IDLE, S_ADDR, S_D0, S_D1, S_D2, S_D3, S_CRC};
    busy_d     = (state_d != S_IDLE);
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= 32'd0;
      crc_q       <= 8'h00;
      crc_act_q   <= 1'b0;
      is_rd_q     <= 1'b0;
      addr_q      <= 8'h00;
      data_q      <= 32'd0;
      cap_q       <= 32'd0;
      rx_ready_q  <= 1'b0;
      csr_wen_q   <= 1'b0;
      csr_ren_q   <= 1'b0;
      csr_addr_q  <= '0;
      csr_wdata_q <= 32'd0;
      tx_valid_q  <= 1'b0;
      tx_data_q   <= 8'h00;
      crc_err_q   <= 1'b0;
      ill_q       <= 1'b0;
      to_q        <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      crc_q       <= crc_d;
      crc_act_q   <= crc_act_d;
      is_rd_q     <= is_rd_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      cap_q       <= cap_d;
      rx_ready_q  <= rx_ready_d;
      csr_wen_q   <= csr_wen_d;
      csr_ren_q   <= csr_ren_d;
      csr_addr_q  <= csr_addr_d;
      csr_wdata_q <= csr_wdata_d;
      tx_valid_q  <= tx_valid_d;
      tx_data_q   <= tx_data_d;
      crc_err_q   <= crc_err_d;
      ill_q       <= ill_d;
      to_q        <= to_d;
      busy_q      <= busy_d;
    end
  end

  assign rx_ready       = rx_ready_q;
  assign csr_wen        = csr_wen_q;
  assign csr_ren        = csr_ren_q;
  assign csr_addr       = csr_addr_q;
  assign csr_wdata      = csr_wdata_q;
  assign tx_valid       = tx_valid_q;
  assign tx_data        = tx_data_q;
  assign rx_crc_error   = CRC_BUILD & crc_err_q;
  assign rx_illegal_cmd = ill_q;
  assign rx_timeout     = to_q;
  assign busy           = busy_q;

endmodule

// File: tb/tb_cmd_rx_parser.sv
// Self-checking bench for cmd_rx_parser: directed packets plus random packets scored by a packet-level model.
module tb_cmd_rx_parser;
  localparam int K_WEN = 0, K_REN = 1, K_ILLCMD = 2, K_ILLADDR = 3, K_CRC = 4;
`ifdef CMD_RX_CRC_EN
  localparam bit CRC_TB = 1'b1;
`else
  localparam bit CRC_TB = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_ready;
  logic        crc_en = 1'b0;
  logic        csr_wen, csr_ren;
  logic [7:0]  csr_addr;
  logic [31:0] csr_wdata;
  logic [31:0] csr_rdata = 32'd0;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready = 1'b1;
  logic        rx_crc_error, rx_illegal_cmd, rx_timeout, busy;
  int          total = 0;
  int          bad = 0;
  logic [7:0]  pkt [0:7];
  int          pkt_len = 0;

  always #5 clk = ~clk;

  cmd_rx_parser #(.TIMEOUT_CYC(32'd16), .ADDR_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
    .crc_en(crc_en), .csr_wen(csr_wen), .csr_ren(csr_ren), .csr_addr(csr_addr),
    .csr_wdata(csr_wdata), .csr_rdata(csr_rdata), .tx_valid(tx_valid), .tx_data(tx_data),
    .tx_ready(tx_ready), .rx_crc_error(rx_crc_error), .rx_illegal_cmd(rx_illegal_cmd),
    .rx_timeout(rx_timeout), .busy(busy)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // CRC of pkt[0..n-1] as remainder of (message * x^8) divided by x^8+x^2+x+1.
  function automatic logic [7:0] ref_crc(input int n);
    logic [8:0] r = 9'd0;
    for (int i = 0; i < n + 1; i++) begin
      for (int b = 7; b >= 0; b--) begin
        r = {r[7:0], (i < n) ? pkt[i][b] : 1'b0};
        if (r[8]) r = r ^ 9'h107;
      end
    end
    return r[7:0];
  endfunction

  task automatic build_pkt(input logic [7:0] cmd, input logic [7:0] addr, input logic [31:0] data,
                           input bit with_crc, input bit corrupt);
    pkt[0]  = cmd;
    pkt_len = 1;
    if (cmd == 8'h01 || cmd == 8'h02) begin
      pkt[1]  = addr;
      pkt_len = 2;
      if (cmd == 8'h01) begin
        for (int k = 0; k < 4; k++) pkt[2 + k] = data[8*k +: 8];
        pkt_len = 6;
      end
      if (with_crc) begin
        pkt[pkt_len] = ref_crc(pkt_len) ^ (corrupt ? 8'hFF : 8'h00);
        pkt_len++;
      end
    end
  endtask

  task automatic model(output int kind, output logic [7:0] ea, output logic [31:0] ed);
    bit crc_act;
    crc_act = CRC_TB && crc_en;
    ea = 8'h00;
    ed = 32'd0;
    if (pkt[0] != 8'h01 && pkt[0] != 8'h02) begin
      kind = K_ILLCMD;
    end else begin
      ea = pkt[1];
      if (pkt[0] == 8'h01) ed = {pkt[5], pkt[4], pkt[3], pkt[2]};
      if (crc_act && ref_crc(pkt_len - 1) != pkt[pkt_len - 1]) kind = K_CRC;
      else if (ea[1:0] != 2'b00) kind = K_ILLADDR;
      else kind = (pkt[0] == 8'h01) ? K_WEN : K_REN;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int w = 0;
    rx_valid = 1'b1;
    rx_data  = b;
    while (rx_ready !== 1'b1 && w < 50) begin
      tick();
      w++;
    end
    if (w == 50) begin
      total++;
      bad++;
      $display("FAIL rx_ready_wait: rx_ready=%b want 1 within 50 cycles", rx_ready);
    end
    tick();
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  task automatic run_packet(input string name, input logic [31:0] rdata, input int stall_mode,
                            input bit settle);
    int kind;
    int stalls;
    logic [7:0]  ea;
    logic [31:0] ed;
    logic [5:0]  exp_f;
    model(kind, ea, ed);
    for (int i = 0; i < pkt_len; i++) begin
      send_byte(pkt[i]);
      if (i < pkt_len - 1) begin
        total++;
        if ({csr_wen, csr_ren, rx_crc_error, rx_illegal_cmd, rx_timeout, busy} !== 6'b000001) begin
          bad++;
          $display("FAIL %s mid_byte%0d: flags=%b want 000001", name, i,
                   {csr_wen, csr_ren, rx_crc_error, rx_illegal_cmd, rx_timeout, busy});
        end
      end
    end
    exp_f = {kind == K_WEN, kind == K_REN, kind == K_CRC, kind == K_ILLCMD || kind == K_ILLADDR,
             1'b0, kind != K_ILLCMD};
    total++;
    if ({csr_wen, csr_ren, rx_crc_error, rx_illegal_cmd, rx_timeout, busy} !== exp_f) begin
      bad++;
      $display("FAIL %s end_flags: flags=%b want %b", name,
               {csr_wen, csr_ren, rx_crc_error, rx_illegal_cmd, rx_timeout, busy}, exp_f);
    end
    total++;
    if (rx_ready !== (kind == K_ILLCMD)) begin
      bad++;
      $display("FAIL %s end_rx_ready: got %b want %b", name, rx_ready, kind == K_ILLCMD);
    end
    if (kind == K_WEN || kind == K_REN) begin
      total++;
      if (csr_addr !== ea || (kind == K_WEN && csr_wdata !== ed)) begin
        bad++;
        $display("FAIL %s addr_data: addr=%h wdata=%h want addr=%h wdata=%h", name,
                 csr_addr, csr_wdata, ea, ed);
      end
    end
    if (kind == K_REN) begin
      csr_rdata = rdata;
      tick();
      total++;
      if ({tx_valid, csr_ren} !== 2'b00) begin
        bad++;
        $display("FAIL %s rd_wait: tx_valid,csr_ren=%b want 00", name, {tx_valid, csr_ren});
      end
      tick();
      csr_rdata = ~rdata;
      for (int k = 0; k < 4; k++) begin
        stalls = (stall_mode == 1 && k == 1) ? 3 : ((stall_mode == 2) ? int'($urandom_range(0, 2)) : 0);
        for (int s = 0; s <= stalls; s++) begin
          total++;
          if (tx_valid !== 1'b1 || tx_data !== rdata[8*k +: 8]) begin
            bad++;
            $display("FAIL %s tx_byte%0d: valid=%b data=%h want valid=1 data=%h", name, k,
                     tx_valid, tx_data, rdata[8*k +: 8]);
          end
          tx_ready = (s == stalls);
          tick();
        end
      end
      tx_ready = 1'b1;
      total++;
      if ({tx_valid, busy, csr_ren} !== 3'b000 || csr_addr !== ea) begin
        bad++;
        $display("FAIL %s tx_done: valid,busy,ren=%b addr=%h want 000 addr=%h", name,
                 {tx_valid, busy, csr_ren}, csr_addr, ea);
      end
    end else if (settle) begin
      tick();
      total++;
      if ({csr_wen, csr_ren, rx_crc_error, rx_illegal_cmd, rx_timeout, busy, tx_valid} !== 7'd0) begin
        bad++;
        $display("FAIL %s settle: flags=%b want 0000000", name,
                 {csr_wen, csr_ren, rx_crc_error, rx_illegal_cmd, rx_timeout, busy, tx_valid});
      end
    end else begin
      stalls = 0;
    end
  endtask

  task automatic test_reset();
    repeat (3) tick();
    total++;
    if ({rx_ready, csr_wen, csr_ren, csr_addr, csr_wdata, tx_valid, tx_data, rx_crc_error,
         rx_illegal_cmd, rx_timeout, busy} !== 57'd0) begin
      bad++;
      $display("FAIL reset_outputs: some output nonzero during reset, want all 0");
    end
    rst_n = 1'b1;
    tick();
    total++;
    if ({rx_ready, busy, tx_valid, csr_wen, csr_ren} !== 5'b10000) begin
      bad++;
      $display("FAIL reset_release: ready,busy,txv,wen,ren=%b want 10000",
               {rx_ready, busy, tx_valid, csr_wen, csr_ren});
    end
  endtask

  task automatic test_write();
    crc_en = 1'b0;
    build_pkt(8'h01, 8'h04, 32'h00000007, 1'b0, 1'b0);
    run_packet("write_basic", 32'd0, 0, 1'b1);
  endtask

  task automatic test_read_stall();
    crc_en = 1'b0;
    build_pkt(8'h02, 8'h40, 32'd0, 1'b0, 1'b0);
    run_packet("read_stall", 32'h000003E8, 1, 1'b1);
    build_pkt(8'h02, 8'h40, 32'd0, 1'b0, 1'b0);
    run_packet("read_b2b_tx", 32'hA5C3_1E77, 0, 1'b1);
  endtask

  task automatic test_crc();
`ifdef CMD_RX_CRC_EN
    crc_en = 1'b1;
    build_pkt(8'h01, 8'h2C, 32'h42AA0000, 1'b1, 1'b0);
    run_packet("crc_good", 32'd0, 0, 1'b1);
    build_pkt(8'h01, 8'h2C, 32'h42AA0000, 1'b1, 1'b1);
    run_packet("crc_bad", 32'd0, 0, 1'b1);
    build_pkt(8'h01, 8'h05, 32'h12345678, 1'b1, 1'b1);
    run_packet("crc_bad_misaligned", 32'd0, 0, 1'b1);
    build_pkt(8'h02, 8'h44, 32'd0, 1'b1, 1'b0);
    run_packet("crc_read", 32'hDEADBEEF, 2, 1'b1);
    crc_en = 1'b0;
    build_pkt(8'h01, 8'h08, 32'h0BADF00D, 1'b0, 1'b0);
    run_packet("crc_runtime_off", 32'd0, 0, 1'b1);
`else
    crc_en = 1'b1;
    build_pkt(8'h01, 8'h2C, 32'h42AA0000, 1'b0, 1'b0);
    run_packet("crc_ignored_wr", 32'd0, 0, 1'b1);
    build_pkt(8'h02, 8'h48, 32'd0, 1'b0, 1'b0);
    run_packet("crc_ignored_rd", 32'h01020304, 0, 1'b1);
    crc_en = 1'b0;
`endif
  endtask

  task automatic test_illegal();
    crc_en = 1'b0;
    build_pkt(8'h7F, 8'h00, 32'd0, 1'b0, 1'b0);
    run_packet("illegal_cmd", 32'd0, 0, 1'b1);
    build_pkt(8'h01, 8'h05, 32'hCAFE0001, 1'b0, 1'b0);
    run_packet("misaligned_wr", 32'd0, 0, 1'b1);
    build_pkt(8'h02, 8'h42, 32'd0, 1'b0, 1'b0);
    run_packet("misaligned_rd", 32'h11223344, 0, 1'b1);
  endtask

  task automatic test_timeout();
    crc_en = 1'b0;
    send_byte(8'h01);
    send_byte(8'h04);
    for (int k = 1; k <= 17; k++) begin
      tick();
      total++;
      if ({rx_timeout, busy, csr_wen} !== ((k < 16) ? 3'b010 : ((k == 16) ? 3'b100 : 3'b000))) begin
        bad++;
        $display("FAIL timeout_cycle%0d: to,busy,wen=%b want %b", k, {rx_timeout, busy, csr_wen},
                 (k < 16) ? 3'b010 : ((k == 16) ? 3'b100 : 3'b000));
      end
    end
    build_pkt(8'h02, 8'h40, 32'd0, 1'b0, 1'b0);
    run_packet("read_after_timeout", 32'h000003E8, 0, 1'b1);
    send_byte(8'h01);
    send_byte(8'h04);
    repeat (15) tick();
    send_byte(8'h07);
    total++;
    if ({rx_timeout, busy} !== 2'b01) begin
      bad++;
      $display("FAIL timeout_byte_wins: to,busy=%b want 01", {rx_timeout, busy});
    end
    for (int k = 0; k < 3; k++) send_byte(8'h00);
    total++;
    if (csr_wen !== 1'b1 || csr_wdata !== 32'h00000007 || csr_addr !== 8'h04) begin
      bad++;
      $display("FAIL timeout_late_write: wen=%b wdata=%h addr=%h want 1 00000007 04",
               csr_wen, csr_wdata, csr_addr);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    crc_en = 1'b0;
    send_byte(8'h01);
    send_byte(8'h04);
    send_byte(8'h07);
    rst_n = 1'b0;
    #1;
    total++;
    if ({rx_ready, csr_wen, csr_ren, csr_addr, csr_wdata, tx_valid, tx_data, rx_crc_error,
         rx_illegal_cmd, rx_timeout, busy} !== 57'd0) begin
      bad++;
      $display("FAIL reset_mid_outputs: some output nonzero in reset, want all 0");
    end
    tick();
    total++;
    if ({csr_wen, rx_timeout, rx_illegal_cmd, busy} !== 4'b0000) begin
      bad++;
      $display("FAIL reset_mid_hold: wen,to,ill,busy=%b want 0000",
               {csr_wen, rx_timeout, rx_illegal_cmd, busy});
    end
    rst_n = 1'b1;
    tick();
    build_pkt(8'h01, 8'h10, 32'h89ABCDEF, 1'b0, 1'b0);
    run_packet("write_after_reset", 32'd0, 0, 1'b1);
  endtask

  task automatic test_back_to_back();
    crc_en = 1'b0;
    build_pkt(8'h01, 8'h20, 32'h5555AAAA, 1'b0, 1'b0);
    run_packet("b2b_write", 32'd0, 0, 1'b0);
    build_pkt(8'h02, 8'h20, 32'd0, 1'b0, 1'b0);
    run_packet("b2b_read", 32'h5555AAAA, 0, 1'b1);
  endtask

  task automatic test_random();
    logic [7:0]  cmd, addr;
    logic [31:0] data;
    bit          crc_on;
    for (int n = 0; n < 30; n++) begin
      crc_en = 1'($urandom_range(0, 1));
      crc_on = CRC_TB && crc_en;
      if ($urandom_range(0, 9) == 0) cmd = 8'($urandom_range(3, 255));
      else cmd = ($urandom_range(0, 1) == 0) ? 8'h01 : 8'h02;
      addr = 8'($urandom);
      if ($urandom_range(0, 9) < 7) addr[1:0] = 2'b00;
      data = 32'($urandom);
      build_pkt(cmd, addr, data, crc_on, $urandom_range(0, 6) == 0);
      run_packet("random", 32'($urandom), 2, 1'($urandom_range(0, 1)));
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_write();
    test_read_stall();
    test_crc();
    test_illegal();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cmd_rx_parser.md
# cmd_rx_parser

Upstream command front-end for the `csr` register block. It consumes the byte stream from the UART receiver and parses fixed-format host packets into single-cycle `csr_wen`/`csr_ren` accesses. Read results are returned as a 4-byte stream to the UART transmitter. It also generates the `rx_crc_error`, `rx_illegal_cmd` and timeout status pulses that `csr` latches into STATUS.

## Interface
- `TIMEOUT_CYC`, 100000: inter-byte timeout in clk cycles while mid-packet; 32-bit range.
- `ADDR_W`, 8: CSR byte-address width.
- `clk` in 1: single clock.
- `rst_n` in 1: reset, asynchronous and active-low.
- `rx_valid` in 1: `rx_data` holds a byte.
- `rx_data` in 8: received byte.
- `rx_ready` out 1: parser accepts the byte; a transfer occurs when `rx_valid && rx_ready`.
- `crc_en` in 1: runtime CRC enable, driven from `csr` `uart_crc_en`.
- `csr_wen` out 1: single-cycle CSR write strobe.
- `csr_ren` out 1: single-cycle CSR read strobe.
- `csr_addr` out ADDR_W: CSR byte address; held stable from the strobe until the next packet.
- `csr_wdata` out 32: write data.
- `csr_rdata` in 32: registered read data, valid one cycle after `csr_ren`.
- `tx_valid` out 1: `tx_data` holds a response byte.
- `tx_data` out 8: response byte.
- `tx_ready` in 1: UART transmitter accepts the byte.
- `rx_crc_error` out 1: one-cycle pulse.
- `rx_illegal_cmd` out 1: one-cycle pulse.
- `rx_timeout` out 1: one-cycle pulse.
- `busy` out 1: high in every state except IDLE.

## Operation
- Packet format:
  - Byte 0 is CMD: 0x01 = WRITE, 0x02 = READ.
  - Byte 1 is ADDR.
  - WRITE only: 4 data bytes follow, LSB first.
  - A CRC byte follows last when CRC is active.
- CRC: CRC-8, poly 0x07, init 0x00, MSB-first, computed over every byte from CMD to the last byte before the CRC. CRC is active when the macro is present and `crc_en` is 1. `crc_en` is sampled on CMD acceptance and held for the whole packet.
- State machine (states and transitions):
  - IDLE → ADDR on any CMD byte.
  - ADDR → D0 (WRITE), → CRC (READ with CRC active), or → EXEC.
  - D0 → D1 → D2 → D3; D3 → CRC or EXEC.
  - CRC → EXEC.
  - EXEC → RD_WAIT (READ) or IDLE (WRITE).
  - RD_WAIT → TX0 → TX1 → TX2 → TX3 → IDLE.
- Unknown CMD (anything other than 0x01/0x02): byte is consumed, `rx_illegal_cmd` pulses, state stays IDLE.
- Misaligned address (`ADDR[1:0] != 0`): the full packet is still received. In EXEC, `rx_illegal_cmd` pulses, no strobe is issued, and the parser returns to IDLE with no TX bytes.
- CRC mismatch: `rx_crc_error` pulses in EXEC, no strobe, return to IDLE, no TX bytes.
- CRC mismatch and misaligned address together: only `rx_crc_error` pulses.
- `rx_ready` is 1 in IDLE, ADDR, D0–D3 and CRC; 0 in EXEC, RD_WAIT and TX*.
- Timeout:
  - A 32-bit idle counter runs in ADDR, D0–D3 and CRC.
  - It clears on every accepted byte.
  - When it reaches `TIMEOUT_CYC`, `rx_timeout` pulses for one cycle and the state goes to IDLE; the partial packet is discarded and no strobe is issued.
- TX: bytes are sent `csr_rdata` LSB first from a capture register loaded in RD_WAIT. Each TX state holds `tx_valid` = 1 until `tx_ready`.

## Timing
- Reset values: all outputs 0, state IDLE, CRC accumulator 0x00, counters 0. `rx_ready` is 1 from the first cycle after reset release. Reset asserted mid-packet or mid-TX aborts immediately without any pulse.
- Write latency: `csr_wen` is high exactly in the cycle after the last byte (D3 or CRC) is accepted. `csr_wdata` and `csr_addr` are valid in that same cycle.
- Read latency:
  - `csr_ren` is high in the cycle after the last byte is accepted.
  - `csr_rdata` is captured the following cycle (RD_WAIT).
  - `tx_valid` rises the cycle after that.
- Back-to-back TX: with `tx_ready` held at 1, the 4 bytes leave on 4 consecutive cycles.
- A byte offered while `rx_ready` = 0 is neither consumed nor dropped; it stays pending at the source.
- Error and timeout pulses are exactly 1 cycle and never overlap a strobe.
- Timeout fires when the counter equals `TIMEOUT_CYC` (counter compare on `==`). A byte accepted in that same cycle wins: the counter clears and no timeout occurs.

## Configuration
- `CMD_RX_CRC_EN` defined: CRC accumulator, CRC state and `rx_crc_error` logic are compiled in and gated at runtime by `crc_en`.
- `CMD_RX_CRC_EN` undefined: `crc_en` is ignored, packets never carry a CRC byte, the CRC state is unreachable, and `rx_crc_error` is tied to 0.

## Test plan
- WRITE with CRC off: bytes 01 04 07 00 00 00 → `csr_wen` = 1 for one cycle, `csr_addr` = 0x04, `csr_wdata` = 0x00000007, no error pulses.
- READ with CRC off, `csr_rdata` = 0x000003E8 at addr 0x40: bytes 02 40 → `csr_ren` for one cycle, then TX bytes E8 03 00 00. Stall `tx_ready` for 3 cycles on byte 1 → that byte is held stable with `tx_valid` = 1.
- CRC on (macro defined, `crc_en` = 1): WRITE 01 2C 00 00 AA 42 plus the correct CRC → `csr_wdata` = 0x42AA0000. Same packet with the CRC XOR 0xFF → `rx_crc_error` pulse, no `csr_wen`, back to IDLE.
- Illegal command and address:
  - CMD 0x7F → `rx_illegal_cmd` pulse, `busy` stays 0.
  - WRITE to ADDR 0x05 → full packet accepted, then `rx_illegal_cmd` pulse and no `csr_wen`.
- Timeout with `TIMEOUT_CYC` = 16: send 01 04 then stop → `rx_timeout` pulses 16 cycles after the ADDR byte is accepted, `busy` falls. A following 02 40 read completes normally.
- Reset mid-packet: assert `rst_n` = 0 after 01 04 07 → all outputs 0 and no strobe. After release, a fresh WRITE succeeds.
